// File: rtl/wishbone_config_loader_if.sv
// Command/response stream and Wishbone initiator signals of wishbone_config_loader.
// master: the loader's view; slave: the command source, response sink and responder.
interface wishbone_config_loader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [1:0]  cmd_reg;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_reg, cmd_sel, cmd_data,
        input  rsp_ready, wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_reg, cmd_sel, cmd_data,
        output rsp_ready, wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wishbone_config_loader.sv
// Turns a valid/ready command stream into single Wishbone classic cycles on a register
// window at BASE_ADDR. Optional ack timeout is built when CFG_LOADER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// REQ   | cyc/stb asserted, waiting for ack (or timeout)
// RESP  | rsp_valid=1, holding result until rsp_ready
module wishbone_config_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    wishbone_config_loader_if.master        bus,
    output logic                            busy,
    output logic [15:0]                     txn_count
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic accept;
    logic complete;
    logic abort;
    logic tmo_hit;

    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] rsp_data_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ack is only looked at in REQ so a trailing responder ack cannot finish a later cycle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.wbm_ack_i) begin
                    complete  = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_hit) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_q  <= 1'b0;
            sel_q <= 4'h0;
            adr_q <= {BASE_ADDR[31:2], 2'b00};
            dat_q <= 32'h0;
        end else if (accept) begin
            we_q  <= bus.cmd_we;
            sel_q <= bus.cmd_we ? bus.cmd_sel : 4'hF;
            adr_q <= {BASE_ADDR[31:2], bus.cmd_reg};
            dat_q <= bus.cmd_data;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_data_q <= 32'h0;
        end else if (complete) begin
            rsp_data_q <= we_q ? 32'h0 : bus.wbm_dat_i;
        end else if (abort) begin
            rsp_data_q <= 32'h0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            txn_count <= 16'h0;
        end else if (complete && txn_count != 16'hFFFF) begin
            txn_count <= txn_count + 16'd1;
        end
    end

`ifdef CFG_LOADER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        rsp_err_q;

    // counts REQ cycles already spent without ack; abort on the last allowed one
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt <= 16'h0;
        end else if (accept) begin
            tmo_cnt <= 16'h0;
        end else if (state == REQ && !bus.wbm_ack_i) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_err_q <= 1'b0;
        end else if (complete) begin
            rsp_err_q <= 1'b0;
        end else if (abort) begin
            rsp_err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.wbm_cyc_o = (state == REQ);
    assign bus.wbm_stb_o = (state == REQ);
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_wishbone_config_loader.sv
// Scoreboard bench for wishbone_config_loader: stimulus pushes expected Wishbone cycles and
// responses into queues, monitors pop and compare when the DUT presents them.
module tb_wishbone_config_loader;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        busy;
    logic [15:0] txn_count;

    wishbone_config_loader_if bus();

    wishbone_config_loader #(
        .BASE_ADDR      (32'h3000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .bus       (bus),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          chk_dat;
    } wb_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_exp_t;

    wb_exp_t  exp_wb[$];
    rsp_exp_t exp_rsp[$];

    int checks   = 0;
    int failures = 0;

    // responder controls
    int          ack_delay = 0;
    logic [31:0] rd_val    = 32'h0;
    bit          no_ack    = 1'b0;
    bit          spurious  = 1'b0;
    logic [15:0] exp_txn   = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Wishbone responder: ack after ack_delay idle REQ cycles, plus forced spurious acks
    initial begin
        int  cnt;
        bit  auto_ack;
        cnt = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = JUNK;
        forever begin
            @(posedge wb_clk_i);
            #2;
            auto_ack = 1'b0;
            if (bus.wbm_cyc_o && bus.wbm_stb_o && !no_ack) begin
                if (cnt == ack_delay) begin
                    auto_ack = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
            bus.wbm_ack_i = auto_ack | spurious;
            bus.wbm_dat_i = auto_ack ? rd_val : JUNK;
        end
    end

    // Wishbone cycle monitor: compare on cyc rise, then check the bus holds stable
    initial begin
        wb_exp_t cur;
        logic    cyc_prev;
        cyc_prev = 1'b0;
        cur = '{adr: 32'h0, we: 1'b0, sel: 4'h0, dat: 32'h0, chk_dat: 1'b0};
        forever begin
            @(negedge wb_clk_i);
            if (bus.wbm_cyc_o) begin
                check("wb_stb_eq_cyc", 32'(bus.wbm_stb_o), 32'd1);
                if (!cyc_prev) begin
                    if (exp_wb.size() == 0) begin
                        check("wb_unexpected_cycle", 32'd1, 32'd0);
                    end else begin
                        cur = exp_wb.pop_front();
                    end
                end
                check("wb_adr", bus.wbm_adr_o, cur.adr);
                check("wb_we", 32'(bus.wbm_we_o), 32'(cur.we));
                check("wb_sel", 32'(bus.wbm_sel_o), 32'(cur.sel));
                if (cur.chk_dat) check("wb_dat", bus.wbm_dat_o, cur.dat);
            end
            cyc_prev = bus.wbm_cyc_o;
        end
    end

    // response monitor: one pop per handshake
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_i && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic push_cmd(input logic we, input logic [1:0] rg, input logic [3:0] sel,
                            input logic [31:0] data, input bit with_rsp,
                            input logic [31:0] rdata, input logic err);
        wb_exp_t w;
        rsp_exp_t r;
        w.adr = {30'h0C00_0000, rg};
        w.we = we;
        w.sel = we ? sel : 4'hF;
        w.dat = data;
        w.chk_dat = we;
        exp_wb.push_back(w);
        if (with_rsp) begin
            r.data = (we || err) ? 32'h0 : rdata;
            r.err = err;
            exp_rsp.push_back(r);
        end
    endtask

    // called #1 after a posedge; returns #1 after the accepting edge
    task automatic send_cmd(input logic we, input logic [1:0] rg, input logic [3:0] sel,
                            input logic [31:0] data, output int waited);
        waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_we = we;
        bus.cmd_reg = rg;
        bus.cmd_sel = sel;
        bus.cmd_data = data;
        @(negedge wb_clk_i);
        while (!bus.cmd_ready && waited < 200) begin
            @(negedge wb_clk_i);
            waited++;
        end
        if (waited >= 200) check("cmd_accept_timeout", 32'd1, 32'd0);
        @(posedge wb_clk_i);
        #1;
        bus.cmd_valid = 1'b0;
        check("cyc_after_accept", 32'(bus.wbm_cyc_o), 32'd1);
        check("cmd_ready_after_accept", 32'(bus.cmd_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge wb_clk_i);
        while (busy && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 200) check("wait_idle_timeout", 32'd1, 32'd0);
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wait_rsp_valid();
        int n = 0;
        @(negedge wb_clk_i);
        while (!bus.rsp_valid && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 200) check("wait_rsp_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_txn(input logic we, input logic [1:0] rg, input logic [3:0] sel,
                          input logic [31:0] data, input logic [31:0] rdata, input int dly);
        int w;
        ack_delay = dly;
        rd_val = rdata;
        push_cmd(we, rg, sel, data, 1'b1, rdata, 1'b0);
        send_cmd(we, rg, sel, data, w);
        wait_idle();
        exp_txn++;
        check("txn_count", 32'(txn_count), 32'(exp_txn));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cyc_cycles;
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_reg = 2'd0;
        bus.cmd_sel = 4'h0;
        bus.cmd_data = 32'h0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge wb_clk_i);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_adr", bus.wbm_adr_o, 32'h3000_0000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_txn_count", 32'(txn_count), 32'd0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // basic writes and reads
        do_txn(1'b1, 2'd0, 4'h1, 32'h0000_0001, 32'h0, 2);
        do_txn(1'b0, 2'd1, 4'h2, 32'h0000_1234, 32'hA5C3_0F81, 0);
        do_txn(1'b1, 2'd3, 4'hC, 32'hCAFE_F00D, 32'h0, 5);
        do_txn(1'b0, 2'd2, 4'h0, 32'h0, 32'h0BAD_F00D, 1);

        // back-pressure with a second command pending
        bus.rsp_ready = 1'b0;
        ack_delay = 1;
        push_cmd(1'b1, 2'd2, 4'hF, 32'h5555_AAAA, 1'b1, 32'h0, 1'b0);
        send_cmd(1'b1, 2'd2, 4'hF, 32'h5555_AAAA, w);
        wait_rsp_valid();
        exp_txn++;
        @(posedge wb_clk_i);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_we = 1'b0;
        bus.cmd_reg = 2'd3;
        bus.cmd_sel = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        end
        @(posedge wb_clk_i);
        #1;
        bus.rsp_ready = 1'b1;
        ack_delay = 3;
        rd_val = 32'h1357_9BDF;
        push_cmd(1'b0, 2'd3, 4'h0, 32'h0, 1'b1, 32'h1357_9BDF, 1'b0);
        send_cmd(1'b0, 2'd3, 4'h0, 32'h0, w);
        check("accept_not_same_as_rsp", 32'(w), 32'd1);
        wait_idle();
        exp_txn++;
        check("txn_count_bp", 32'(txn_count), 32'(exp_txn));

        // spurious ack while idle
        spurious = 1'b1;
        repeat (3) begin
            @(negedge wb_clk_i);
            check("spur_idle_busy", 32'(busy), 32'd0);
            check("spur_idle_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            check("spur_idle_txn", 32'(txn_count), 32'(exp_txn));
        end
        @(posedge wb_clk_i);
        #1;
        spurious = 1'b0;
        @(posedge wb_clk_i);
        #1;

        // spurious ack while holding a response
        bus.rsp_ready = 1'b0;
        ack_delay = 0;
        rd_val = 32'h8000_0001;
        push_cmd(1'b0, 2'd0, 4'h0, 32'h0, 1'b1, 32'h8000_0001, 1'b0);
        send_cmd(1'b0, 2'd0, 4'h0, 32'h0, w);
        wait_rsp_valid();
        exp_txn++;
        @(posedge wb_clk_i);
        #1;
        spurious = 1'b1;
        repeat (3) begin
            @(negedge wb_clk_i);
            check("spur_resp_valid", 32'(bus.rsp_valid), 32'd1);
            check("spur_resp_data", bus.rsp_data, 32'h8000_0001);
            check("spur_resp_cyc", 32'(bus.wbm_cyc_o), 32'd0);
            check("spur_resp_txn", 32'(txn_count), 32'(exp_txn));
        end
        @(posedge wb_clk_i);
        #1;
        spurious = 1'b0;
        @(posedge wb_clk_i);
        #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

`ifdef CFG_LOADER_TIMEOUT_EN
        // no ack: abort after 8 REQ cycles
        no_ack = 1'b1;
        push_cmd(1'b0, 2'd1, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        send_cmd(1'b0, 2'd1, 4'h0, 32'h0, w);
        cyc_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk_i);
            if (!bus.wbm_cyc_o) break;
            cyc_cycles++;
        end
        check("timeout_req_cycles", 32'(cyc_cycles), 32'd8);
        wait_idle();
        no_ack = 1'b0;
        check("timeout_txn_count", 32'(txn_count), 32'(exp_txn));
`endif

        // asynchronous reset in the middle of REQ
        no_ack = 1'b1;
        push_cmd(1'b1, 2'd1, 4'h3, 32'h0000_0077, 1'b0, 32'h0, 1'b0);
        send_cmd(1'b1, 2'd1, 4'h3, 32'h0000_0077, w);
        @(negedge wb_clk_i);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("arst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check("arst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("arst_txn_count", 32'(txn_count), 32'd0);
        check("arst_adr", bus.wbm_adr_o, 32'h3000_0000);
        exp_txn = 16'h0;
        no_ack = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        do_txn(1'b1, 2'd0, 4'hF, 32'h0000_00FF, 32'h0, 1);

        repeat (3) @(posedge wb_clk_i);
        check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wishbone_config_loader.md
Name: wishbone_config_loader

Overview:
- Wishbone initiator that drives the configuration responder's register window from a simple command stream (valid/ready), so on-chip logic can program the fabric without the management core.
- Each accepted command becomes exactly one single Wishbone classic cycle (read or write) to BASE_ADDR plus a 2-bit register index.
- The result (read data or error flag) is returned on a response handshake.
- Sits between a command source (FIFO, boot ROM sequencer) and the configuration responder's Wishbone slave port.

Parameters:
- BASE_ADDR, 32'h3000_0000, responder base address; bits [31:2] drive wbm_adr_o[31:2].
- TIMEOUT_CYCLES, 255, cycles to wait for ack before aborting; only used when CFG_LOADER_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  loader can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_reg  in  2  register index, driven onto wbm_adr_o[1:0].
- cmd_sel  in  4  byte mask for writes.
- cmd_data  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  32  read data (0 for writes and errors).
- rsp_err  out  1  cycle aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- busy  out  1  state != IDLE.
- txn_count  out  16  completed (acked) transactions, saturating at 16'hFFFF.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous, active-high.
- Reset values: all registered outputs 0, cmd_ready=1 (combinational from IDLE), wbm_adr_o={BASE_ADDR[31:2],2'b00}. State returns to IDLE.
- Reset mid-cycle: drops cyc/stb immediately (async); no response is produced.
- State machine: IDLE, REQ, RESP, all registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: capture we/reg/sel/data into the wbm_* registers and go to REQ.
  - cyc/stb rise on the cycle after acceptance (1-cycle latency).
- REQ:
  - cyc=stb=1; we/sel/adr/dat held stable; cmd_ready=0.
  - On posedge with wbm_ack_i=1:
    - cyc/stb go to 0.
    - rsp_data = we ? 0 : wbm_dat_i.
    - rsp_err = 0.
    - txn_count increments unless already 16'hFFFF.
    - Go to RESP.
  - ack is sampled only in REQ; ack in IDLE/RESP is ignored (the responder's trailing ack must not complete a later cycle).
- RESP:
  - rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE the same edge; the next command can be accepted the following cycle.
  - No command is accepted in the same cycle a response is taken.
- Minimum command-to-command spacing: 3 cycles plus responder latency.
- wbm_sel_o during reads: 4'b1111 regardless of cmd_sel.
- Back-pressure: rsp_ready held low keeps the loader in RESP indefinitely. cmd_ready stays 0 and no Wishbone activity occurs.
- Only one outstanding transaction ever exists; no pipelining, no burst (CTI/BTE not driven).

Optional Feature:
- Macro: CFG_LOADER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, cyc/stb drop, rsp_err=1, rsp_data=0, txn_count unchanged, go to RESP.
  - Ack on the same edge as the timeout wins (normal completion).
- Undefined:
  - No counter; REQ waits for ack forever; rsp_err is tied 0.

Test Plan:
- Write reg0: cmd_we=1, reg=0, sel=4'h1, data=32'h1; responder acks after 2 cycles -> exactly one cycle with adr=32'h3000_0000, we=1, dat=1; rsp_valid with rsp_data=0, rsp_err=0; txn_count=1.
- Read reg1 with wbm_dat_i=32'hA5C3_0F81 at ack -> adr=32'h3000_0001, sel=4'hF, we=0; rsp_data=32'hA5C3_0F81.
- Hold rsp_ready=0 for 10 cycles with a second cmd_valid pending -> cmd_ready=0 and cyc=0 throughout; second cycle starts 1 cycle after IDLE acceptance.
- Spurious wbm_ack_i=1 while IDLE and during RESP -> no state change, txn_count unchanged.
- With CFG_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack never asserted -> cyc drops after 8 REQ cycles; rsp_err=1, rsp_data=0; txn_count unchanged.
- Assert wb_rst_i asynchronously mid-REQ -> cyc/stb/rsp_valid=0 immediately, txn_count=0; a new command completes normally afterwards.
